prio_enc_8to3: RTL
==================

// Module: prio_enc_8to3
// PURPOSE
//  Registered, debounced 8-to-3 priority encoder. It is the inverse of the 3-to-8 line decoder in the LED project.
//  It samples 8 asynchronous switch/button lines, synchronises and debounces them as one vector, then encodes the
//  highest-numbered asserted line into a 3-bit code with a valid flag and a one-cycle change event.
//  Sits between board switches and LED/decoder logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  default 50000  cycles the synced vector must hold unchanged before commit (>=2)
//  CNT_W            default 16     debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        in   1  single clock; all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  Enable     in   1  active-high; low forces outputs to zero and restarts debounce
//  I          in   8  raw asynchronous input lines, I[7] highest priority
//  Y          out  3  code of highest asserted committed line
//  valid      out  1  1 when any committed line is asserted
//  evt        out  1  one-cycle pulse when {valid,Y} changes
//  multi      out  1  (only with PRIO_ENC_MULTI_ERR_EN) >1 committed line asserted
// BEHAVIOUR
//  Reset (async assert, sync release by clk): sync regs, samp, cnt, Y, valid, evt, multi all 0.
//  Sync: 2-FF synchroniser, I -> s1 -> s2.
//  Debounce, each cycle:
//   - s2 != samp: samp<=s2, cnt<=0.
//   - otherwise, cnt != DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - otherwise: commit. cnt holds (saturates), re-commits each cycle.
//  Commit: Y<=index of MSB set in samp, valid<=|samp. Y=0 when samp==0.
//  evt<=1 on the commit cycle where the new {valid,Y} != the current registered {valid,Y}; else evt<=0.
//  evt never lasts more than 1 cycle.
//  Latency: I stable at edge 0 -> Y/valid updated after edge DEBOUNCE_CYCLES+3.
//  Glitch: any s2 change before cnt saturates restarts the count; no output change.
//  Changes in low-priority bits only: recommit, {valid,Y} unchanged, no evt.
//  Enable low (sampled): Y,valid,multi<=0. samp<=0, cnt<=0. evt<=1 for one cycle if valid was 1.
//   Synchroniser keeps running.
//  Enable rising: debounce restarts from samp=0; first commit follows the normal latency rules.
//  Reset mid-count: all state cleared immediately; no evt on release.
// CONFIGURATION
//  PRIO_ENC_MULTI_ERR_EN defined: port multi exists. On commit, multi<=(popcount(samp)>1).
//   multi is 0 when Enable is low or in reset. multi does not affect evt.
//  Undefined: no multi port, no popcount logic; all else identical.
// STRUCTURE
//  Package prio_enc_pkg: localparam N_IN=8, CODE_W=3, and function msb_index(8b)->3b.
//  Sub-module prio_enc_debounce: sync + samp/cnt; outputs stable vector + commit strobe.
//  Top does encode/evt/multi.
// TESTING  (DEBOUNCE_CYCLES=4, CNT_W=3)
//  1 Reset: rst_n=0 mid-run -> Y=0,valid=0,evt=0 immediately; after release, I=0 -> no evt.
//  2 I=8'h00->8'h24 held -> after 7 cycles Y=5, valid=1, evt=1 exactly 1 cycle.
//  3 I=8'h24 with 2-cycle glitch to 8'h80 -> Y stays 5, no evt.
//    Then I=8'h80 held -> Y=7, evt pulses once.
//  4 I=8'h81->8'h80 (low bit drops) -> Y stays 7, valid=1, no evt; multi 1->0 (macro on).
//  5 valid=1, Enable=0 -> next cycle Y=0, valid=0, evt 1 cycle.
//    Enable=1 with I=8'h02 -> Y=1 after 7 cycles, evt.
//  6 Sweep I=1<<k, k=0..7 with full debounce each -> Y=k, valid=1, multi=0.
//    I=8'hFF -> Y=7, multi=1 (macro on); build without macro compiles and matches otherwise.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered, debounced 8-to-3 priority encoder.
package prio_enc_pkg;

    localparam int unsigned N_IN   = 8;
    localparam int unsigned CODE_W = 3;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [CODE_W-1:0] msb_index(input logic [N_IN-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_enc_8to3_debounce.sv
// Two-flop synchroniser plus whole-vector debounce.
// Emits the debounced vector and a commit strobe that stays high once the
// vector has held for DEBOUNCE_CYCLES cycles.
module prio_enc_8to3_debounce
    import prio_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [N_IN-1:0] raw_i,
    output logic [N_IN-1:0] vec_o,
    output logic            commit_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  s1_q, s2_q;
    logic [N_IN-1:0]  samp_q, samp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    // Debounce next state: restart on change, count while stable, saturate at commit.
    always_comb begin
        samp_d = samp_q;
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (!en_i) begin
            samp_d = '0;
            cnt_d  = '0;
        end else if (s2_q != samp_q) begin
            samp_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d  = cnt_q + 1'b1;
        end else begin
            commit = 1'b1;
        end
    end

    // Synchroniser runs regardless of enable; debounce state follows next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            samp_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            samp_q <= samp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign vec_o    = samp_q;
    assign commit_o = commit;

endmodule

// File: rtl/prio_enc_8to3.sv
// Registered, debounced 8-to-3 priority encoder with valid flag and change event.
// Optional feature macro: PRIO_ENC_MULTI_ERR_EN adds the 'multi' output.
module prio_enc_8to3
    import prio_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic [N_IN-1:0]   I,
    output logic [CODE_W-1:0] Y,
`ifdef PRIO_ENC_MULTI_ERR_EN
    output logic              multi,
`endif
    output logic              valid,
    output logic              evt
);

    logic [N_IN-1:0]   vec;
    logic              commit;
    logic [CODE_W-1:0] y_q, y_d;
    logic              valid_q, valid_d;
    logic              evt_q, evt_d;

    prio_enc_8to3_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (Enable),
        .raw_i   (I),
        .vec_o   (vec),
        .commit_o(commit)
    );

    // Encode on commit; disable clears outputs and reports the drop of valid.
    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        evt_d   = 1'b0;
        if (!Enable) begin
            y_d     = '0;
            valid_d = 1'b0;
            evt_d   = valid_q;
        end else if (commit) begin
            y_d     = msb_index(vec);
            valid_d = |vec;
            evt_d   = ({valid_d, y_d} != {valid_q, y_q});
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            evt_q   <= evt_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign evt   = evt_q;

`ifdef PRIO_ENC_MULTI_ERR_EN
    logic multi_q, multi_d;

    // More than one committed line: clearing the lowest set bit leaves something.
    always_comb begin
        multi_d = multi_q;
        if (!Enable) begin
            multi_d = 1'b0;
        end else if (commit) begin
            multi_d = ((vec & (vec - 1'b1)) != '0);
        end
    end

    // Multi-line flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi = multi_q;
`endif

endmodule
